// File: rtl/tetris_pkg.sv
// rtl/tetris_pkg.sv - shared board geometry, scoring constants and line-clear sequencer state type
package tetris_pkg;

  localparam int ROWS    = 20;
  localparam int COLS    = 10;
  localparam int ROW_AW  = 5;
  localparam int SCORE_W = 20;
  localparam int LINES_W = 16;
  localparam int PTS_W   = 11;

  localparam logic [PTS_W-1:0] PTS_1     = 11'd40;
  localparam logic [PTS_W-1:0] PTS_2     = 11'd100;
  localparam logic [PTS_W-1:0] PTS_3     = 11'd300;
  localparam logic [PTS_W-1:0] PTS_4PLUS = 11'd1200;

  typedef enum logic [2:0] {
    LCS_IDLE,
    LCS_SCAN,
    LCS_COPY,
    LCS_FILL,
    LCS_DONE
  } lcs_state_t;

endpackage

// File: rtl/line_score_lut.sv
// rtl/line_score_lut.sv - maps a count of cleared lines to the points it awards
module line_score_lut
  import tetris_pkg::*;
(
  input  logic [ROW_AW-1:0] lines,
  output logic [PTS_W-1:0]  points
);

  // Anything beyond a four-line clear is still worth a four-line clear.
  always_comb begin
    points = PTS_4PLUS;
    case (lines)
      ROW_AW'(0): points = '0;
      ROW_AW'(1): points = PTS_1;
      ROW_AW'(2): points = PTS_2;
      ROW_AW'(3): points = PTS_3;
      default:    points = PTS_4PLUS;
    endcase
  end

endmodule

// File: rtl/line_clear_sequencer.sv
// rtl/line_clear_sequencer.sv - removes completed rows in one bottom-up pass and keeps line/score totals
module line_clear_sequencer
  import tetris_pkg::*;
#(
  parameter int ROWS = tetris_pkg::ROWS,
  parameter int COLS = tetris_pkg::COLS
) (
  input  logic               clock,
  input  logic               resetn,
  input  logic               start,
  input  logic [ROWS-1:0]    completed_lines,
  output logic [ROW_AW-1:0]  row_rd_addr,
  input  logic [COLS-1:0]    row_rd_data,
  output logic               row_wr_en,
  output logic [ROW_AW-1:0]  row_wr_addr,
  output logic [COLS-1:0]    row_wr_data,
  output logic               busy,
  output logic               done,
  output logic [ROW_AW-1:0]  lines_cleared,
  output logic [LINES_W-1:0] total_lines,
  output logic [SCORE_W-1:0] score
);

  localparam logic [ROW_AW-1:0] LAST_ROW = ROW_AW'(ROWS - 1);

  lcs_state_t        state, state_n;
  logic [ROWS-1:0]   mask, mask_n;
  logic [ROW_AW-1:0] rd, rd_n, wr, wr_n, cnt, cnt_n;

  logic [PTS_W-1:0]   points;
  logic [LINES_W:0]   lines_sum;
  logic [SCORE_W:0]   score_sum;
  logic               enter_done;

  line_score_lut u_lut (
    .lines  (cnt_n),
    .points (points)
  );

  assign lines_sum  = {1'b0, total_lines} + {{(LINES_W + 1 - ROW_AW){1'b0}}, cnt_n};
  assign score_sum  = {1'b0, score} + {{(SCORE_W + 1 - PTS_W){1'b0}}, points};
  assign enter_done = (state_n == LCS_DONE) && (state != LCS_DONE);

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state         <= LCS_IDLE;
      mask          <= '0;
      rd            <= '0;
      wr            <= '0;
      cnt           <= '0;
      lines_cleared <= '0;
      total_lines   <= '0;
      score         <= '0;
    end else begin
      state <= state_n;
      mask  <= mask_n;
      rd    <= rd_n;
      wr    <= wr_n;
      cnt   <= cnt_n;
      // Totals land on the edge into DONE so they are stable while done is high.
      if (enter_done) begin
        lines_cleared <= cnt_n;
        total_lines   <= lines_sum[LINES_W] ? {LINES_W{1'b1}} : lines_sum[LINES_W-1:0];
        score         <= score_sum[SCORE_W] ? {SCORE_W{1'b1}} : score_sum[SCORE_W-1:0];
      end
    end
  end

  always_comb begin
    state_n     = state;
    mask_n      = mask;
    rd_n        = rd;
    wr_n        = wr;
    cnt_n       = cnt;
    busy        = (state != LCS_IDLE);
    done        = 1'b0;
    row_rd_addr = '0;
    row_wr_en   = 1'b0;
    row_wr_addr = '0;
    row_wr_data = '0;
    case (state)
      LCS_IDLE: begin
        if (start) begin
          mask_n  = completed_lines;
          rd_n    = LAST_ROW;
          wr_n    = LAST_ROW;
          cnt_n   = '0;
          state_n = (completed_lines == '0) ? LCS_DONE : LCS_SCAN;
        end
      end
      LCS_SCAN: begin
        // Removed rows and rows already in place cost one cycle and no memory access.
        if (mask[rd] || (rd == wr)) begin
          if (mask[rd]) cnt_n = cnt + ROW_AW'(1);
          else          wr_n  = wr - ROW_AW'(1);
          if (rd == '0) state_n = LCS_FILL;
          else          rd_n    = rd - ROW_AW'(1);
        end else begin
          row_rd_addr = rd;
          state_n     = LCS_COPY;
        end
      end
      LCS_COPY: begin
        row_wr_en   = 1'b1;
        row_wr_addr = wr;
        row_wr_data = row_rd_data;
        wr_n        = wr - ROW_AW'(1);
        if (rd == '0) begin
          state_n = LCS_FILL;
        end else begin
          rd_n    = rd - ROW_AW'(1);
          state_n = LCS_SCAN;
        end
      end
      LCS_FILL: begin
        row_wr_en   = 1'b1;
        row_wr_addr = wr;
        if (wr == '0) state_n = LCS_DONE;
        else          wr_n    = wr - ROW_AW'(1);
      end
      LCS_DONE: begin
        done    = 1'b1;
        state_n = LCS_IDLE;
      end
      default: state_n = LCS_IDLE;
    endcase
  end

endmodule

// File: doc/line_clear_sequencer.md
# line_clear_sequencer

Compacts the 20×10 Tetris board after a piece lands. It removes every row flagged in `completed_lines`, shifts all surviving rows down, and zero-fills the vacated top rows, all in a single bottom-to-top pass over the board row memory. It also maintains the cleared-line and score counters. It sits between the game control FSM, which pulses `start` in its check-lines step and waits for `done`, and the board row RAM, which is shared with the renderer only while `busy` is low.

## Interface
Parameters:
- `ROWS`, default 20: board height; row 0 is the top, row ROWS-1 is the bottom.
- `COLS`, default 10: row width in cells.

Ports:
- `clock` in 1: single clock, rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `start` in 1: one-cycle request; sampled only in IDLE.
- `completed_lines` in ROWS: full-row mask; bit r is row r; sampled with `start`.
- `row_rd_addr` out 5: board read address; data returns 1 cycle later.
- `row_rd_data` in COLS: board read data.
- `row_wr_en` out 1: board write strobe.
- `row_wr_addr` out 5: board write address.
- `row_wr_data` out COLS: board write data.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle completion pulse.
- `lines_cleared` out 5: popcount of the last mask; held until the next accepted `start`.
- `total_lines` out 16: running line total; saturates at 0xFFFF.
- `score` out 20: running score; saturates at 0xFFFFF.

## Operation
- States: IDLE, SCAN, COPY, FILL, DONE.
- Registers: `mask` (ROWS), `rd` (5b), `wr` (5b), `cnt` (5b).
- IDLE, on `start`: latch `mask`; set `rd=wr=ROWS-1` and `cnt=0`.
  - mask==0 → DONE.
  - otherwise → SCAN.
- SCAN examines row `rd`:
  - mask[rd] set: cnt++ (no memory access).
  - rd==wr: no write needed; wr--.
  - otherwise: drive `row_rd_addr=rd` → COPY.
  - In the first two cases: if rd==0 → FILL, else rd-- and stay in SCAN.
- COPY: `row_wr_en=1`, `row_wr_addr=wr`, `row_wr_data=row_rd_data`. Then wr--. If rd==0 → FILL, else rd-- → SCAN.
- FILL: `row_wr_en=1`, `row_wr_addr=wr`, `row_wr_data=0`. If wr==0 → DONE, else wr--. The number of FILL writes equals `cnt`.
- DONE: `done=1` for one cycle → IDLE.
- Counter update, on the edge entering DONE (so values are valid while `done` is high):
  - `lines_cleared=cnt`.
  - `total_lines += cnt`, saturating.
  - `score += points(cnt)`, saturating.
- points(n): 0→0, 1→40, 2→100, 3→300, n≥4→1200. Masks wider than 4 lines are legal and score 1200.
- `start` while `busy` is ignored, with no queuing. `completed_lines` is don't-care outside the `start` cycle.
- Rows below the lowest completed row are never read or written.

## Timing
- Reset values: state IDLE; `busy`, `done`, `row_wr_en`, `lines_cleared`, `total_lines`, `score` all 0; `row_rd_addr`, `row_wr_addr`, `row_wr_data` all 0.
- Reset mid-operation aborts immediately; the board may be partially compacted, and the control FSM resets the board alongside this block.
- Memory outputs are registered-state decodes; `row_rd_data` is consumed exactly in the COPY cycle after the SCAN that addressed it.
- `busy` rises on the edge after `start` is accepted. `done` and `busy` fall together on the edge leaving DONE.
- Latency from the `start` edge, for ROWS=20:
  - mask=0: `done` at cycle 1.
  - top row only: `done` at cycle 22.
  - bottom row only: `done` at cycle 41.
  - Worst case, all 20 rows: 20 SCAN + 20 FILL + DONE = cycle 41.
- A new `start` is accepted on the first IDLE cycle after `done`.

## Structure
- Package `tetris_pkg` holds:
  - ROWS=20, COLS=10, ROW_AW=5.
  - The state enum for this block.
  - Score constants 40/100/300/1200 and the widths SCORE_W=20, LINES_W=16.
- Sub-module `line_score_lut`: combinational cnt→points mapping, reused by the display/high-score logic.
- The sequencer itself is a single always_ff plus a next-state/output always_comb.

## Test plan
- Mask 0x00000, board random → `done` at cycle 1; no `row_wr_en`; lines_cleared=0; score unchanged.
- Mask bit 19 only, row r preloaded with pattern r → after `done` (cycle 41): row 0=0 and row r=pattern r-1 for r=1..19; score=40; total_lines=1.
- Mask bits 19,17,16,10 → rows compact correctly; rows 0–3 are 0; lines_cleared=4; score +1200; rows 0..9 from the original shifted by 4 except removed rows.
- Mask 0xFFFFF → all rows 0; lines_cleared=20; score +1200; `done` at cycle 41; zero reads issued.
- `start` pulsed mid-operation and `resetn` dropped mid-COPY → the first has no effect; the second gives immediate IDLE and all outputs 0 asynchronously.
- total_lines preset near 0xFFFF via repeated clears → it saturates at 0xFFFF; the score saturation check is analogous at 0xFFFFF.
